layer_seq_ctrl: RTL and testbench

LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

---
 rtl/layer_ctrl_pkg.sv | 25 ++
 rtl/stage_wdog.sv | 32 +++
 rtl/layer_seq_ctrl.sv | 97 +++++++++
 tb/tb_layer_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_ctrl_pkg.sv
// Shared stage indices, stage count and controller state encoding for the layer sequencer.
// Imported by the sequencer top and its stage watchdog.
package layer_ctrl_pkg;

    localparam int NUM_STAGE = 7;

    localparam logic [2:0] STG_LN1     = 3'd0;
    localparam logic [2:0] STG_QKV     = 3'd1;
    localparam logic [2:0] STG_ATTN    = 3'd2;
    localparam logic [2:0] STG_PROJ    = 3'd3;
    localparam logic [2:0] STG_LN2     = 3'd4;
    localparam logic [2:0] STG_LINEAR1 = 3'd5;
    localparam logic [2:0] STG_LINEAR2 = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    function automatic logic [NUM_STAGE-1:0] stg_onehot(input logic [2:0] s);
        return NUM_STAGE'(1) << s;
    endfunction

endpackage

// File: rtl/stage_wdog.sv
// Per-stage cycle watchdog: counts while enabled, clears on each stage launch.
// expired is combinational and flags the cycle whose increment would reach limit; limit=0 disables it.
module stage_wdog #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_nxt;
        end
    end

    // Firing one cycle early lets the error flag land exactly limit cycles after the stage start.
    assign expired = en && !clr && (limit != '0) && (cnt_nxt == limit);

endmodule

// File: rtl/layer_seq_ctrl.sv
// Sequences the seven stages of one transformer layer, one-hot start pulses, 1-cycle step latency.
// No backpressure: stray done bits and ln_start outside IDLE are dropped; a stage timeout locks in ERR until rst.
module layer_seq_ctrl
    import layer_ctrl_pkg::*;
#(
    parameter  int NUM_LAYER   = 12,
    parameter  int TIMEOUT_CYC = 65535,
    localparam int IDX_W       = (NUM_LAYER > 1) ? $clog2(NUM_LAYER) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ln_start,
    input  logic                 layer_clr,
    output logic                 linear2_done,
    output logic [NUM_STAGE-1:0] stg_start,
    input  logic [NUM_STAGE-1:0] stg_done,
    output logic [IDX_W-1:0]     layer_idx,
    output logic                 busy,
    output logic                 err,
    output logic [2:0]           err_stage
);

    localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t     state;
    logic [2:0] stg;
    logic       cur_done;
    logic       launch;
    logic       expired;

    assign cur_done = (state == ST_RUN) && stg_done[stg];
    assign launch   = ((state == ST_IDLE) && ln_start) || (cur_done && (stg != STG_LINEAR2));

    stage_wdog #(.W(WD_W)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (launch),
        .en      (state == ST_RUN),
        .limit   (WD_W'(TIMEOUT_CYC)),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            stg          <= STG_LN1;
            layer_idx    <= '0;
            err          <= 1'b0;
            err_stage    <= 3'd0;
            busy         <= 1'b0;
            stg_start    <= '0;
            linear2_done <= 1'b0;
        end else begin
            stg_start    <= '0;
            linear2_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (layer_clr) begin
                        layer_idx <= '0;
                    end
                    if (ln_start) begin
                        state     <= ST_RUN;
                        stg       <= STG_LN1;
                        stg_start <= stg_onehot(STG_LN1);
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A done in the expiry cycle still counts as on time.
                    if (cur_done) begin
                        if (stg == STG_LINEAR2) begin
                            state        <= ST_IDLE;
                            stg          <= STG_LN1;
                            busy         <= 1'b0;
                            linear2_done <= 1'b1;
                            layer_idx    <= (layer_idx == IDX_W'(NUM_LAYER - 1)) ?
                                            '0 : layer_idx + IDX_W'(1);
                        end else begin
                            stg       <= stg + 3'd1;
                            stg_start <= stg_onehot(stg + 3'd1);
                        end
                    end else if (expired) begin
                        state     <= ST_ERR;
                        err       <= 1'b1;
                        err_stage <= stg;
                    end
                end
                ST_ERR: begin
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl: the driver pushes expected events from a cycle-timeline model,
// a negedge monitor pops and compares every start pulse, layer completion and error rise.
module tb_layer_seq_ctrl;

    localparam int NL = 12;
    localparam int TO = 100;

    localparam int EV_START = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int kind;
        int arg;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ln_start;
    logic       layer_clr;
    logic       linear2_done;
    logic [6:0] stg_start;
    logic [6:0] stg_done;
    logic [3:0] layer_idx;
    logic       busy;
    logic       err;
    logic [2:0] err_stage;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_idx = 0;
    int   dly [7];
    ev_t  exp_q [$];
    logic err_q = 1'b0;

    layer_seq_ctrl #(.NUM_LAYER(NL), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ln_start     (ln_start),
        .layer_clr    (layer_clr),
        .linear2_done (linear2_done),
        .stg_start    (stg_start),
        .stg_done     (stg_done),
        .layer_idx    (layer_idx),
        .busy         (busy),
        .err          (err),
        .err_stage    (err_stage)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    function automatic void push(input int kind, input int arg, input int at);
        ev_t e;
        e.kind = kind;
        e.arg  = arg;
        e.cyc  = at;
        exp_q.push_back(e);
    endfunction

    // Monitor: any observable event must match the head of the expectation queue.
    always @(negedge clk) begin : mon
        ev_t e;
        int  kind;
        int  arg;
        if (stg_start != '0 || linear2_done || (err && !err_q)) begin
            if (stg_start != '0) begin
                kind = EV_START;
                arg  = -1;
                for (int b = 0; b < 7; b++) if (stg_start[b]) arg = b;
                check("stg_start_onehot", int'($onehot(stg_start)), 1);
            end else if (linear2_done) begin
                kind = EV_DONE;
                arg  = int'(layer_idx);
            end else begin
                kind = EV_ERR;
                arg  = int'(err_stage);
            end
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got kind %0d arg %0d, expected none (cycle %0d)", kind, arg, cyc);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", kind, e.kind);
                check("event_arg", arg, e.arg);
                check("event_cycle", cyc, e.cyc);
            end
        end
        err_q = err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_dly();
        for (int k = 0; k < 7; k++) dly[k] = $urandom_range(2, 12);
    endtask

    // Drives one layer open-loop from the model timeline: stage k starts at s, its done is
    // raised dly[k] cycles later, and the next start is expected the cycle after that.
    task automatic do_layer(input int gap, input bit clr_w_start, input bit spur,
                            input int hold_stg, input int rst_stg);
        int s;
        for (int g = 0; g < gap; g++) begin
            stg_done = spur ? 7'($urandom) : 7'd0;
            tick();
            stg_done = '0;
        end
        ln_start  = 1'b1;
        layer_clr = clr_w_start;
        if (clr_w_start) m_idx = 0;
        s = cyc + 1;
        push(EV_START, 0, s);
        tick();
        ln_start  = 1'b0;
        layer_clr = 1'b0;
        check("busy_in_run", int'(busy), 1);
        for (int k = 0; k < 7; k++) begin
            if (k == rst_stg) begin
                repeat (2) tick();
                stg_done = '0;
                rst = 1'b1;
                #1;
                check("rst_stg_start", int'(stg_start), 0);
                check("rst_l2done", int'(linear2_done), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_layer_idx", int'(layer_idx), 0);
                tick();
                rst = 1'b0;
                m_idx = 0;
                tick();
                check("post_rst_busy", int'(busy), 0);
                check("post_rst_err", int'(err), 0);
                return;
            end
            if (k == hold_stg) begin
                push(EV_ERR, k, s + TO);
                repeat (TO + 50) begin
                    ln_start = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                    stg_done = spur ? 7'($urandom) & ~(7'd1 << k) : 7'd0;
                    tick();
                end
                ln_start = 1'b0;
                stg_done = '0;
                tick();
                check("err_sticky", int'(err), 1);
                check("err_stage", int'(err_stage), k);
                check("busy_in_err", int'(busy), 1);
                return;
            end
            for (int w = 0; w < dly[k]; w++) begin
                ln_start = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                stg_done = spur ? 7'($urandom) & ~(7'd1 << k) : 7'd0;
                if (spur && k == 1 && w == 1) begin
                    stg_done[4] = 1'b1;
                    ln_start    = 1'b1;
                end
                tick();
            end
            stg_done = (7'd1 << k) | (spur ? 7'($urandom) : 7'd0);
            ln_start = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            s = cyc + 1;
            if (k < 6) begin
                push(EV_START, k + 1, s);
            end else begin
                m_idx = (m_idx + 1) % NL;
                push(EV_DONE, m_idx, s);
            end
            tick();
            stg_done = '0;
            ln_start = 1'b0;
        end
        check("busy_after_layer", int'(busy), 0);
    endtask

    initial begin
        rst       = 1'b1;
        ln_start  = 1'b0;
        layer_clr = 1'b0;
        stg_done  = '0;
        repeat (3) tick();
        check("reset_stg_start", int'(stg_start), 0);
        check("reset_l2done", int'(linear2_done), 0);
        check("reset_layer_idx", int'(layer_idx), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err), 0);
        check("reset_err_stage", int'(err_stage), 0);
        rst = 1'b0;
        while (cyc < 10) tick();

        // Nominal layer, every stage done 5 cycles after its start.
        for (int k = 0; k < 7; k++) dly[k] = 5;
        do_layer(0, 1'b0, 1'b0, -1, -1);
        check("nominal_layer_idx", int'(layer_idx), 1);

        layer_clr = 1'b1;
        tick();
        layer_clr = 1'b0;
        m_idx = 0;
        check("layer_clr_idle", int'(layer_idx), 0);

        // Twelve back-to-back layers walking the index through its wrap.
        for (int i = 0; i < NL; i++) begin
            rand_dly();
            do_layer((i == 0) ? 2 : 0, 1'b0, 1'b1, -1, -1);
        end
        check("wrap_layer_idx", int'(layer_idx), 0);

        rand_dly();
        do_layer(3, 1'b1, 1'b1, -1, -1);
        check("clr_with_start_idx", int'(layer_idx), 1);

        // Done for stage 3 lands in the watchdog expiry cycle.
        rand_dly();
        dly[3] = TO - 1;
        do_layer(2, 1'b0, 1'b1, -1, -1);
        check("race_err_clear", int'(err), 0);

        rand_dly();
        do_layer(2, 1'b0, 1'b1, -1, 5);
        check("queue_empty_after_rst", exp_q.size(), 0);

        rand_dly();
        do_layer(1, 1'b0, 1'b0, -1, -1);
        check("restart_layer_idx", int'(layer_idx), 1);

        rand_dly();
        do_layer(1, 1'b0, 1'b1, 2, -1);

        repeat (3) tick();
        check("queue_empty_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within 50000 cycles");
        $fatal(1);
    end

endmodule
